// File: rtl/jtag_dr_bank_if.sv
// TAP-side signal bundle for jtag_dr_bank: the TAP drives state flags and data,
// the bank returns tdo.
interface jtag_dr_bank_if #(
   parameter int unsigned IR_LENGTH = 4
);
   logic                 tck;
   logic                 tdi;
   logic [IR_LENGTH-1:0] ir;
   logic                 capture_dr;
   logic                 shift_dr;
   logic                 update_dr;
   logic                 tdo;

   modport master (output tck, tdi, ir, capture_dr, shift_dr, update_dr, input tdo);
   modport slave  (input tck, tdi, ir, capture_dr, shift_dr, update_dr, output tdo);
endinterface

// File: rtl/jtag_dr_bank.sv
// IR-selected bank of JTAG data registers in the clk_50_ domain, with TAP
// synchronisers, bypass fallthrough, shift-length checking and update strobes.
module jtag_dr_bank #(
   parameter int unsigned IR_LENGTH   = 4,
   parameter int unsigned NCHAN       = 4,
   parameter int unsigned DR_WIDTH    = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRICT_LEN  = 1
) (
   input  logic                      clk_50_,
   input  logic                      rst_n,
   jtag_dr_bank_if.slave             tap,
   input  logic [NCHAN*DR_WIDTH-1:0] cap_data,
   output logic [NCHAN*DR_WIDTH-1:0] dr_out,
   output logic [NCHAN-1:0]          upd_strobe,
   output logic                      len_err,
   output logic                      busy
);
   localparam int unsigned CNT_W  = $clog2(DR_WIDTH + 2);
   localparam int unsigned SYNC_W = IR_LENGTH + 5;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_WIDTH);

   typedef enum logic [1:0] {StIdle, StShift, StUpd} state_e;

   state_e                    state_q;
   logic [SYNC_W-1:0]         sync_q [SYNC_STAGES];
   logic                      tck_prev_q;
   logic [DR_WIDTH-1:0]       sr_q;
   logic [CNT_W-1:0]          count_q;
   logic [IR_LENGTH-1:0]      sel_q;
   logic                      tdo_q;
   logic [NCHAN*DR_WIDTH-1:0] dr_out_q;
   logic [NCHAN-1:0]          upd_strobe_q;
   logic                      len_err_q;
   logic                      busy_q;

   logic                 s_tck, s_tdi, s_cap, s_shift, s_upd;
   logic [IR_LENGTH-1:0] s_ir;
   logic                 tck_rise, tck_fall;
   logic [DR_WIDTH-1:0]  cap_word;
   logic                 sel_is_chan;
   logic                 len_ok;

   assign {s_tck, s_tdi, s_cap, s_shift, s_upd, s_ir} = sync_q[SYNC_STAGES-1];
   assign tck_rise = s_tck & ~tck_prev_q;
   assign tck_fall = ~s_tck & tck_prev_q;
   assign len_ok   = (STRICT_LEN != 0) ? (count_q == CNT_FULL) : (count_q != '0);

   // Capture source follows the live synced ir; unmapped codes capture 0 (bypass).
   always_comb begin
      cap_word    = '0;
      sel_is_chan = 1'b0;
      for (int k = 0; k < NCHAN; k++) begin
         if (s_ir == IR_LENGTH'(k)) cap_word = cap_data[k*DR_WIDTH +: DR_WIDTH];
         if (sel_q == IR_LENGTH'(k)) sel_is_chan = 1'b1;
      end
   end

   always_ff @(posedge clk_50_) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         tck_prev_q   <= 1'b0;
         state_q      <= StIdle;
         sr_q         <= '0;
         count_q      <= '0;
         sel_q        <= '0;
         tdo_q        <= 1'b0;
         dr_out_q     <= '0;
         upd_strobe_q <= '0;
         len_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sync_q[0] <= {tap.tck, tap.tdi, tap.capture_dr, tap.shift_dr, tap.update_dr, tap.ir};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         tck_prev_q   <= s_tck;
         upd_strobe_q <= '0;
         len_err_q    <= 1'b0;

         if (tck_fall && state_q != StIdle) tdo_q <= sr_q[0];

         unique case (state_q)
            StIdle: begin
               if (tck_rise && s_cap) begin
                  sel_q   <= s_ir;
                  sr_q    <= cap_word;
                  count_q <= '0;
                  state_q <= StShift;
                  busy_q  <= 1'b1;
               end
            end
            StShift: begin
               if (tck_rise) begin
                  if (s_cap) begin
                     sel_q   <= s_ir;
                     sr_q    <= cap_word;
                     count_q <= '0;
                  end else if (s_upd) begin
                     state_q <= StUpd;
                  end else if (s_shift) begin
                     if (sel_is_chan) sr_q <= {s_tdi, sr_q[DR_WIDTH-1:1]};
                     else             sr_q[0] <= s_tdi;
                     if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
                  end
               end
            end
            StUpd: begin
               // Bypass selections fall through silently.
               if (sel_is_chan) begin
                  if (len_ok) begin
                     for (int k = 0; k < NCHAN; k++) begin
                        if (sel_q == IR_LENGTH'(k)) begin
                           dr_out_q[k*DR_WIDTH +: DR_WIDTH] <= sr_q;
                           upd_strobe_q[k]                  <= 1'b1;
                        end
                     end
                  end else begin
                     len_err_q <= 1'b1;
                  end
               end
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tap.tdo    = tdo_q;
   assign dr_out     = dr_out_q;
   assign upd_strobe = upd_strobe_q;
   assign len_err    = len_err_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_jtag_dr_bank.sv
// Bench for jtag_dr_bank: strict and non-strict instances share one TAP stimulus
// and are checked against a queue-based model of the data registers.
module tb_jtag_dr_bank;
   localparam int NCH = 4;
   localparam int W   = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic             tck = 1'b0, tdi = 1'b0;
   logic             capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
   logic [3:0]       ir = '0;
   logic [NCH*W-1:0] cap_data = '0;
   logic [NCH*W-1:0] dr_s, dr_n;
   logic [NCH-1:0]   stb_s, stb_n;
   logic             err_s, err_n, busy_s, busy_n;

   jtag_dr_bank_if #(.IR_LENGTH(4)) tap_s ();
   jtag_dr_bank_if #(.IR_LENGTH(4)) tap_n ();

   assign tap_s.tck = tck;  assign tap_s.tdi = tdi;  assign tap_s.ir = ir;
   assign tap_s.capture_dr = capture_dr;  assign tap_s.shift_dr = shift_dr;
   assign tap_s.update_dr = update_dr;
   assign tap_n.tck = tck;  assign tap_n.tdi = tdi;  assign tap_n.ir = ir;
   assign tap_n.capture_dr = capture_dr;  assign tap_n.shift_dr = shift_dr;
   assign tap_n.update_dr = update_dr;

   jtag_dr_bank #(.IR_LENGTH(4), .NCHAN(NCH), .DR_WIDTH(W), .SYNC_STAGES(2), .STRICT_LEN(1)) dut_s (
      .clk_50_(clk), .rst_n(rst_n), .tap(tap_s), .cap_data(cap_data), .dr_out(dr_s),
      .upd_strobe(stb_s), .len_err(err_s), .busy(busy_s));
   jtag_dr_bank #(.IR_LENGTH(4), .NCHAN(NCH), .DR_WIDTH(W), .SYNC_STAGES(2), .STRICT_LEN(0)) dut_n (
      .clk_50_(clk), .rst_n(rst_n), .tap(tap_n), .cap_data(cap_data), .dr_out(dr_n),
      .upd_strobe(stb_n), .len_err(err_n), .busy(busy_n));

   int total = 0, bad = 0;
   logic [W-1:0] model_s [NCH];
   logic [W-1:0] model_n [NCH];
   int exp_stb_s [NCH], exp_stb_n [NCH], act_stb_s [NCH], act_stb_n [NCH];
   int exp_err_s = 0, exp_err_n = 0, act_err_s = 0, act_err_n = 0;
   int overlap = 0, long_pulse = 0;
   logic [NCH:0] prev_s = '0, prev_n = '0;

   // Pulse counters plus shape violations (overlap, wider than one cycle).
   always @(negedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (stb_s[k] === 1'b1) act_stb_s[k]++;
         if (stb_n[k] === 1'b1) act_stb_n[k]++;
      end
      if (err_s === 1'b1) act_err_s++;
      if (err_n === 1'b1) act_err_n++;
      if ((err_s === 1'b1 && |stb_s) || (err_n === 1'b1 && |stb_n)) overlap++;
      if ((|({err_s, stb_s} & prev_s)) === 1'b1 || (|({err_n, stb_n} & prev_n)) === 1'b1)
         long_pulse++;
      prev_s = {err_s, stb_s};
      prev_n = {err_n, stb_n};
   end

   function automatic logic [NCH*W-1:0] pack(input logic [W-1:0] m [NCH]);
      logic [NCH*W-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*W +: W] = m[k];
      return r;
   endfunction

   function automatic logic [W-1:0] capw_of(input int irv);
      if (irv < NCH) return cap_data[irv*W +: W];
      return '0;
   endfunction

   // Register modelled as a FIFO: captured word LSB first, shifted bits appended.
   task automatic model_apply(input int irv, input int nbits, input logic [63:0] bits,
                              input logic [W-1:0] capw, output logic [63:0] exp_tdo);
      logic q[$];
      logic [W-1:0] word;
      exp_tdo = '0;
      word = '0;
      if (irv < NCH) for (int i = 0; i < W; i++) q.push_back(capw[i]);
      else q.push_back(1'b0);
      for (int i = 0; i < nbits; i++) begin
         exp_tdo[i] = q.pop_front();
         q.push_back(bits[i]);
      end
      if (irv < NCH) begin
         for (int i = 0; i < W; i++) word[i] = q[i];
         if (nbits == W) begin model_s[irv] = word; exp_stb_s[irv]++; end
         else exp_err_s++;
         if (nbits >= 1) begin model_n[irv] = word; exp_stb_n[irv]++; end
         else exp_err_n++;
      end
   endtask

   task automatic tap_cycle(input logic c, input logic s, input logic u, input logic d,
                            output logic tdo_b);
      @(negedge clk);
      capture_dr = c; shift_dr = s; update_dr = u; tdi = d;
      repeat (4) @(negedge clk);
      tdo_b = tap_s.tdo;
      tck = 1'b1;
      repeat (8) @(negedge clk);
      tck = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic xfer(input int irv, input int nbits, input logic [63:0] bits,
                       input int late_ir, input int late_at, output logic [63:0] tdo_seen);
      logic b;
      tdo_seen = '0;
      ir = 4'(irv);
      tap_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < nbits; i++) begin
         if (i == late_at) ir = 4'(late_ir);
         tap_cycle(1'b0, 1'b1, 1'b0, bits[i], b);
         tdo_seen[i] = b;
      end
      tap_cycle(1'b0, 1'b0, 1'b1, 1'b0, b);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < NCH; k++) begin model_s[k] = '0; model_n[k] = '0; end
      total++; if (dr_s !== '0) begin bad++; $display("FAIL reset dr_s got=%h want=0", dr_s); end
      total++; if (dr_n !== '0) begin bad++; $display("FAIL reset dr_n got=%h want=0", dr_n); end
      total++;
      if ({stb_s, err_s, busy_s, tap_s.tdo} !== '0) begin
         bad++; $display("FAIL reset flags got=%b want=0", {stb_s, err_s, busy_s, tap_s.tdo});
      end
   endtask

   task automatic test_exact_write();
      logic b;
      logic [63:0] bits, exp_tdo;
      cap_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      bits = 64'hA5A5_0F0F;
      model_apply(2, W, bits, capw_of(2), exp_tdo);
      ir = 4'd2;
      tap_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
      total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL exact busy got=%b want=1", busy_s); end
      for (int i = 0; i < W; i++) tap_cycle(1'b0, 1'b1, 1'b0, bits[i], b);
      tap_cycle(1'b0, 1'b0, 1'b1, 1'b0, b);
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL exact busy_idle got=%b want=0", busy_s); end
      total++;
      if (dr_s[95:64] !== 32'hA5A5_0F0F) begin
         bad++; $display("FAIL exact ch2 got=%h want=a5a50f0f", dr_s[95:64]);
      end
      total++; if (dr_s !== pack(model_s)) begin bad++; $display("FAIL exact dr_s got=%h want=%h", dr_s, pack(model_s)); end
      total++;
      if (act_stb_s != exp_stb_s) begin
         bad++; $display("FAIL exact strobes got=%p want=%p", act_stb_s, exp_stb_s);
      end
   endtask

   task automatic test_readback();
      logic [63:0] seen, exp_tdo;
      cap_data[63:32] = 32'h1234_5678;
      model_apply(1, W, 64'd0, capw_of(1), exp_tdo);
      xfer(1, W, 64'd0, 0, -1, seen);
      total++;
      if (seen[31:0] !== 32'h1234_5678) begin
         bad++; $display("FAIL readback tdo got=%h want=12345678", seen[31:0]);
      end
      total++; if (dr_s[63:32] !== 32'h0) begin bad++; $display("FAIL readback ch1 got=%h want=0", dr_s[63:32]); end
      total++; if (dr_n !== pack(model_n)) begin bad++; $display("FAIL readback dr_n got=%h want=%h", dr_n, pack(model_n)); end
   endtask

   task automatic test_len_err();
      logic [63:0] seen, exp_tdo, bits;
      logic [NCH*W-1:0] saved;
      int err0;
      for (int n = 31; n <= 33; n += 2) begin
         saved = dr_s;
         err0 = act_err_s;
         bits = {$urandom(), $urandom()};
         model_apply(3, n, bits, capw_of(3), exp_tdo);
         xfer(3, n, bits, 0, -1, seen);
         total++; if (act_err_s !== err0 + 1) begin bad++; $display("FAIL len_err n=%0d got=%0d want=%0d", n, act_err_s, err0 + 1); end
         total++; if (dr_s !== saved) begin bad++; $display("FAIL len_keep n=%0d got=%h want=%h", n, dr_s, saved); end
         total++; if (dr_n !== pack(model_n)) begin bad++; $display("FAIL len_loose n=%0d got=%h want=%h", n, dr_n, pack(model_n)); end
      end
      cap_data[31:0] = '0;
      model_apply(0, 8, 64'hFF, capw_of(0), exp_tdo);
      xfer(0, 8, 64'hFF, 0, -1, seen);
      total++; if (dr_n[31:0] !== 32'hFF00_0000) begin bad++; $display("FAIL loose_short got=%h want=ff000000", dr_n[31:0]); end
      total++; if (act_err_s !== exp_err_s) begin bad++; $display("FAIL len_err_total got=%0d want=%0d", act_err_s, exp_err_s); end
      total++; if (act_err_n !== exp_err_n) begin bad++; $display("FAIL len_err_loose got=%0d want=%0d", act_err_n, exp_err_n); end
   endtask

   task automatic test_bypass();
      logic [63:0] seen, exp_tdo;
      model_apply(9, 3, 64'b101, 32'd0, exp_tdo);
      xfer(9, 3, 64'b101, 0, -1, seen);
      total++; if (seen[2:0] !== 3'b010) begin bad++; $display("FAIL bypass tdo got=%b want=010", seen[2:0]); end
      total++;
      if (act_stb_s != exp_stb_s || act_err_s !== exp_err_s) begin
         bad++; $display("FAIL bypass pulses got=%p/%0d want=%p/%0d", act_stb_s, act_err_s, exp_stb_s, exp_err_s);
      end
   endtask

   task automatic test_ir_change();
      logic [63:0] seen, exp_tdo, bits;
      bits = {32'd0, $urandom()};
      model_apply(0, W, bits, capw_of(0), exp_tdo);
      xfer(0, W, bits, 3, 10, seen);
      total++; if (dr_s[31:0] !== bits[31:0]) begin bad++; $display("FAIL irchg ch0 got=%h want=%h", dr_s[31:0], bits[31:0]); end
      total++; if (dr_s !== pack(model_s)) begin bad++; $display("FAIL irchg dr_s got=%h want=%h", dr_s, pack(model_s)); end
   endtask

   task automatic test_recapture();
      logic b;
      logic [63:0] bits, exp_tdo;
      cap_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      bits = {$urandom(), $urandom()};
      model_apply(3, W, bits, capw_of(3), exp_tdo);
      ir = 4'd1;
      tap_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < 5; i++) tap_cycle(1'b0, 1'b1, 1'b0, $urandom_range(0, 1) != 0, b);
      ir = 4'd3;
      tap_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < W; i++) tap_cycle(1'b0, 1'b1, 1'b0, bits[i], b);
      tap_cycle(1'b0, 1'b0, 1'b1, 1'b0, b);
      total++; if (dr_s !== pack(model_s)) begin bad++; $display("FAIL recap dr_s got=%h want=%h", dr_s, pack(model_s)); end
      total++;
      if (act_stb_s != exp_stb_s) begin
         bad++; $display("FAIL recap strobes got=%p want=%p", act_stb_s, exp_stb_s);
      end
   endtask

   task automatic test_reset_mid();
      logic b;
      ir = 4'd2;
      tap_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < 16; i++) tap_cycle(1'b0, 1'b1, 1'b0, 1'b1, b);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < NCH; k++) begin model_s[k] = '0; model_n[k] = '0; end
      total++; if ({dr_s, dr_n} !== '0) begin bad++; $display("FAIL rstmid dr got=%h/%h want=0", dr_s, dr_n); end
      total++;
      if ({busy_s, busy_n, tap_s.tdo, err_s, stb_s} !== '0) begin
         bad++; $display("FAIL rstmid flags got=%b want=0", {busy_s, busy_n, tap_s.tdo, err_s, stb_s});
      end
      tap_cycle(1'b0, 1'b0, 1'b1, 1'b0, b);
      total++;
      if (act_stb_s != exp_stb_s || act_stb_n != exp_stb_n || act_err_s !== exp_err_s) begin
         bad++; $display("FAIL idle_update pulses got=%p/%0d want=%p/%0d", act_stb_s, act_err_s, exp_stb_s, exp_err_s);
      end
      total++; if (dr_s !== '0) begin bad++; $display("FAIL idle_update dr_s got=%h want=0", dr_s); end
   endtask

   task automatic test_random();
      logic [63:0] seen, exp_tdo, bits;
      int irv, n;
      for (int t = 0; t < 12; t++) begin
         cap_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         irv = $urandom_range(0, 5);
         if (irv >= NCH) irv = $urandom_range(NCH, 15);
         case ($urandom_range(0, 3))
            0, 1:    n = W;
            2:       n = $urandom_range(1, 34);
            default: n = ($urandom_range(0, 1) != 0) ? W + 1 : W - 1;
         endcase
         bits = {$urandom(), $urandom()};
         model_apply(irv, n, bits, capw_of(irv), exp_tdo);
         xfer(irv, n, bits, $urandom_range(0, 15), $urandom_range(0, 40), seen);
         total++; if (seen !== exp_tdo) begin bad++; $display("FAIL rand%0d tdo got=%h want=%h", t, seen, exp_tdo); end
         total++; if (dr_s !== pack(model_s)) begin bad++; $display("FAIL rand%0d dr_s got=%h want=%h", t, dr_s, pack(model_s)); end
         total++; if (dr_n !== pack(model_n)) begin bad++; $display("FAIL rand%0d dr_n got=%h want=%h", t, dr_n, pack(model_n)); end
      end
      total++;
      if (act_stb_s != exp_stb_s || act_stb_n != exp_stb_n) begin
         bad++; $display("FAIL rand strobes got=%p/%p want=%p/%p", act_stb_s, act_stb_n, exp_stb_s, exp_stb_n);
      end
      total++;
      if (act_err_s !== exp_err_s || act_err_n !== exp_err_n) begin
         bad++; $display("FAIL rand errs got=%0d/%0d want=%0d/%0d", act_err_s, act_err_n, exp_err_s, exp_err_n);
      end
   endtask

   task automatic test_pulse_shape();
      total++; if (overlap !== 0) begin bad++; $display("FAIL overlap got=%0d want=0", overlap); end
      total++; if (long_pulse !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", long_pulse); end
   endtask

   initial begin
      test_reset();
      test_exact_write();
      test_readback();
      test_len_err();
      test_bypass();
      test_ir_change();
      test_recapture();
      test_reset_mid();
      test_random();
      test_pulse_shape();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
